// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory loader.
package cpu_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_FINISH,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input channel and instruction-memory write port of the loader.
interface imem_loader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
);

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   imem_we;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Shifts program bytes MSB-first into a 32-bit word and flags the byte that completes it.
module byte_packer
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]             count_q, count_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    count_d   = count_q;
    shift_d   = shift_q;
    word_full = accept && (count_q == LAST_BYTE);
    if (clear) begin
      count_d = '0;
      shift_d = '0;
    end else if (accept) begin
      count_d = count_q + 2'd1;
      shift_d = {shift_q[INSTR_WIDTH-9:0], byte_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  assign word = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-serial program image into instruction memory while holding the core in reset.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_WIDTH:0] word_count
);

  loader_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   last_q, last_d;

  logic                   accept;
  logic                   load_start;
  logic                   word_full;
  logic [INSTR_WIDTH-1:0] packed_word;

  assign accept     = (state_q == ST_COLLECT) && bus.in_valid;
  assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .accept    (accept),
    .byte_in   (bus.in_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (load_start) begin
          state_d = ST_COLLECT;
          addr_d  = '0;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (word_full) begin
            last_d  = bus.in_last;
            state_d = ST_WRITE;
          end else if (bus.in_last) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        wdata_d = packed_word;
        // The last address has no successor: a longer image is an overflow, not a wrap.
        if (last_q) begin
          state_d = ST_FINISH;
        end else if (&addr_q) begin
          state_d = ST_ERROR;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  // The packer's word is stable through WRITE; wdata_q keeps it visible once shifting resumes.
  assign bus.in_ready   = (state_q == ST_COLLECT);
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = (state_q == ST_WRITE) ? packed_word : wdata_q;

  assign cpu_hold   = (state_q == ST_COLLECT) || (state_q == ST_WRITE) || (state_q == ST_ERROR);
  assign done       = (state_q == ST_FINISH);
  assign error      = (state_q == ST_ERROR);
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized checks of imem_loader against a word-level model of the load.
module tb_imem_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sel = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8)) ifa ();
  imem_loader_if #(.ADDR_WIDTH(2)) ifb ();

  logic       start_a, start_b;
  logic       hold_a, done_a, err_a, hold_b, done_b, err_b;
  logic [8:0] wc_a;
  logic [2:0] wc_b;

  assign start_a      = start & ~sel;
  assign start_b      = start & sel;
  assign ifa.in_valid = valid & ~sel;
  assign ifb.in_valid = valid & sel;
  assign ifa.in_data  = data;
  assign ifb.in_data  = data;
  assign ifa.in_last  = last;
  assign ifb.in_last  = last;

  imem_loader #(.ADDR_WIDTH(8)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .bus        (ifa),
    .cpu_hold   (hold_a),
    .done       (done_a),
    .error      (err_a),
    .word_count (wc_a)
  );

  imem_loader #(.ADDR_WIDTH(2)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .bus        (ifb),
    .cpu_hold   (hold_b),
    .done       (done_b),
    .error      (err_b),
    .word_count (wc_b)
  );

  // View of whichever loader is currently selected.
  logic        r_ready, r_we, r_hold, r_done, r_err;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [8:0]  r_wc;

  always_comb begin
    if (sel) begin
      r_ready = ifb.in_ready;
      r_we    = ifb.imem_we;
      r_addr  = {6'b0, ifb.imem_addr};
      r_wdata = ifb.imem_wdata;
      r_hold  = hold_b;
      r_done  = done_b;
      r_err   = err_b;
      r_wc    = {6'b0, wc_b};
    end else begin
      r_ready = ifa.in_ready;
      r_we    = ifa.imem_we;
      r_addr  = ifa.imem_addr;
      r_wdata = ifa.imem_wdata;
      r_hold  = hold_a;
      r_done  = done_a;
      r_err   = err_a;
      r_wc    = wc_a;
    end
  end

  logic [39:0] wlog[$];
  int          done_total = 0;
  int          hold_low = 0;
  logic        loading = 1'b0;

  always @(negedge clk) begin
    if (r_we) wlog.push_back({r_addr, r_wdata});
    if (r_done) done_total <= done_total + 1;
    if (loading && !r_hold && !r_done) hold_low <= hold_low + 1;
  end

  logic [7:0] stim[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic l, input int gap);
    int n;
    valid = 1'b0;
    repeat (gap) begin
      data = 8'($urandom);
      last = 1'($urandom);
      tick();
    end
    valid = 1'b1;
    data  = b;
    last  = l;
    n = 0;
    while (!r_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("accept_wait", 64'(n < 20), 64'(1));
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic loadClean();
    stim = '{8'h00, 8'hA9, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h08, 8'h01};
  endtask

  // Expected results follow from byte count alone: whole words up to capacity are written,
  // anything left over (partial word or bytes past capacity) ends in error.
  task automatic applyStimulus(input int last_idx, input int cap, input int max_gap, input int pulse_at);
    int   nbytes, accepted, exp_writes, w0, d0, h0, got, ready_cycles;
    logic overflow, exp_err;
    logic [31:0] exp_word;
    nbytes     = last_idx + 1;
    overflow   = nbytes > cap * WORD_BYTES;
    accepted   = overflow ? cap * WORD_BYTES : nbytes;
    exp_writes = accepted / WORD_BYTES;
    exp_err    = overflow || (accepted % WORD_BYTES) != 0;
    w0 = wlog.size();
    d0 = done_total;
    h0 = hold_low;
    ready_cycles = 0;

    tick();
    pulseStart();
    loading = 1'b1;
    checkOutput("start_hold", 64'(r_hold), 64'(1));
    checkOutput("start_err", 64'(r_err), 64'(0));
    checkOutput("start_wc", 64'(r_wc), 64'(0));

    for (int i = 0; i < accepted; i++) begin
      sendByte(stim[i], i == last_idx, $urandom_range(0, max_gap));
      if (i == pulse_at) pulseStart();
    end

    if (overflow) begin
      valid = 1'b1;
      data  = stim[accepted];
      last  = (accepted == last_idx);
      repeat (6) begin
        if (r_ready) ready_cycles++;
        tick();
      end
      valid = 1'b0;
      last  = 1'b0;
      checkOutput("overflow_ready", 64'(ready_cycles), 64'(0));
    end

    repeat (8) begin
      tick();
      if (r_done) loading = 1'b0;
    end
    loading = 1'b0;

    got = wlog.size() - w0;
    checkOutput("write_count", 64'(got), 64'(exp_writes));
    for (int k = 0; k < exp_writes && k < got; k++) begin
      exp_word = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
      checkOutput("write_addr", 64'(wlog[w0+k][39:32]), 64'(k));
      checkOutput("write_data", 64'(wlog[w0+k][31:0]), 64'(exp_word));
    end
    checkOutput("done_pulses", 64'(done_total - d0), 64'(!exp_err));
    checkOutput("word_count", 64'(r_wc), 64'(exp_writes));
    checkOutput("error_flag", 64'(r_err), 64'(exp_err));
    checkOutput("hold_after", 64'(r_hold), 64'(exp_err));
    checkOutput("ready_after", 64'(r_ready), 64'(0));
    checkOutput("hold_during", 64'(hold_low - h0), 64'(0));
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_ready"}, 64'(ifa.in_ready), 64'(0));
    checkOutput({tag, "_we"}, 64'(ifa.imem_we), 64'(0));
    checkOutput({tag, "_addr"}, 64'(ifa.imem_addr), 64'(0));
    checkOutput({tag, "_wdata"}, 64'(ifa.imem_wdata), 64'(0));
    checkOutput({tag, "_hold"}, 64'(hold_a), 64'(0));
    checkOutput({tag, "_done"}, 64'(done_a), 64'(0));
    checkOutput({tag, "_err"}, 64'(err_a), 64'(0));
    checkOutput({tag, "_wc"}, 64'(wc_a), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0;
    int len;

    repeat (3) tick();
    checkResetA("reset");
    checkOutput("reset_b_hold", 64'(hold_b), 64'(0));
    checkOutput("reset_b_wc", 64'(wc_b), 64'(0));
    reset = 1'b1;
    tick();

    $display("[TB] clean two-word load");
    loadClean();
    applyStimulus(7, 256, 0, -1);

    $display("[TB] clean load with in_valid gaps");
    repeat (3) begin
      loadClean();
      applyStimulus(7, 256, 3, -1);
    end

    $display("[TB] in_last on sixth byte, then reload");
    loadClean();
    applyStimulus(5, 256, 1, -1);
    loadClean();
    applyStimulus(7, 256, 0, -1);

    $display("[TB] start pulsed during collect");
    loadClean();
    applyStimulus(7, 256, 2, 1);

    $display("[TB] reset after five bytes");
    loadClean();
    w0 = wlog.size();
    tick();
    pulseStart();
    for (int i = 0; i < 5; i++) sendByte(stim[i], 1'b0, 0);
    reset = 1'b0;
    tick();
    checkResetA("midreset");
    reset = 1'b1;
    repeat (8) tick();
    checkOutput("midreset_writes", 64'(wlog.size() - w0), 64'(1));
    checkOutput("midreset_idle_hold", 64'(hold_a), 64'(0));
    loadClean();
    applyStimulus(7, 256, 0, -1);

    $display("[TB] four-word memory with five-word image");
    sel = 1'b1;
    tick();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
    applyStimulus(19, 4, 1, -1);
    loadClean();
    applyStimulus(7, 4, 0, -1);

    $display("[TB] randomized loads");
    for (int t = 0; t < 10; t++) begin
      sel = (t >= 7);
      tick();
      len = sel ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 40));
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
      applyStimulus(len - 1, sel ? 4 : 256, 3, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
